// File: rtl/req_dispatch_queue.sv
// Request dispatch queue: routes {opcode,key,text,dest} instructions by opcode
// into NCH independent first-word-fall-through FIFOs, one per crypto engine.
module req_dispatch_queue #(
   parameter int ADDRW   = 24,
   parameter int OPCODEW = 2,
   parameter int QDEPTH  = 4,
   parameter int NCH     = 2,
   localparam int INSTRW = 3*ADDRW + OPCODEW,
   localparam int CHW    = $clog2(NCH),
   localparam int PTRW   = $clog2(QDEPTH),
   localparam int CNTW   = PTRW + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [OPCODEW-1:0]      opcode,
   input  logic [ADDRW-1:0]        key_addr,
   input  logic [ADDRW-1:0]        text_addr,
   input  logic [ADDRW-1:0]        dest_addr,
   output logic [NCH*INSTRW-1:0]   out_instr,
   output logic [NCH-1:0]          out_valid,
   input  logic [NCH-1:0]          out_ready,
   input  logic [NCH-1:0]          flush,
   output logic [NCH*CNTW-1:0]     count
);

   logic [CHW-1:0]    sel_ch;
   logic [INSTRW-1:0] in_entry;
   logic [NCH-1:0]    full;
   logic              accept;

   assign sel_ch   = opcode[CHW-1:0];
   assign in_entry = {opcode, key_addr, text_addr, dest_addr};

   // Ready depends only on the selected channel's state, never on in_valid.
   assign in_ready = !full[sel_ch] && !flush[sel_ch];
   assign accept   = in_valid && in_ready;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [INSTRW-1:0] mem [QDEPTH];
      logic [PTRW-1:0]   wr_ptr;
      logic [PTRW-1:0]   rd_ptr;
      logic [CNTW-1:0]   cnt;
      logic [CNTW-1:0]   cnt_next;
      logic              push;
      logic              pop;

      assign push = accept && (sel_ch == CHW'(c));
      assign pop  = out_valid[c] && out_ready[c] && !flush[c];

      always_comb begin
         // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
         cnt_next = cnt;
         case ({push, pop})
            2'b10:   cnt_next = cnt + CNTW'(1);
            2'b01:   cnt_next = cnt - CNTW'(1);
            default: cnt_next = cnt;
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            // NOTE: storage is cleared on reset so out_instr reads zero afterwards; drop this loop if that guarantee is not needed.
            for (int i = 0; i < QDEPTH; i++) begin
               mem[i] <= '0;
            end
         end else if (flush[c]) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
         end else begin
            if (push) begin
               mem[wr_ptr] <= in_entry;
               wr_ptr      <= wr_ptr + PTRW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTRW'(1);
            end
            cnt <= cnt_next;
         end
      end

      assign full[c]                    = (cnt == CNTW'(QDEPTH));
      assign out_valid[c]               = (cnt != '0);
      assign out_instr[c*INSTRW +: INSTRW] = mem[rd_ptr];
      assign count[c*CNTW +: CNTW]      = cnt;
   end

endmodule

// File: tb/tb_req_dispatch_queue.sv
// Self-checking bench for req_dispatch_queue: directed scenarios plus random
// traffic, checked by a negedge monitor against per-channel queue models.
module tb_req_dispatch_queue;

   localparam int ADDRW   = 24;
   localparam int OPCODEW = 2;
   localparam int QDEPTH  = 4;
   localparam int NCH     = 2;
   localparam int INSTRW  = 3*ADDRW + OPCODEW;
   localparam int CNTW    = $clog2(QDEPTH) + 1;

   typedef logic [INSTRW-1:0] entry_t;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  in_valid;
   logic                  in_ready;
   logic [OPCODEW-1:0]    opcode;
   logic [ADDRW-1:0]      key_addr;
   logic [ADDRW-1:0]      text_addr;
   logic [ADDRW-1:0]      dest_addr;
   logic [NCH*INSTRW-1:0] out_instr;
   logic [NCH-1:0]        out_valid;
   logic [NCH-1:0]        out_ready;
   logic [NCH-1:0]        flush;
   logic [NCH*CNTW-1:0]   count;

   int total = 0;
   int bad   = 0;

   entry_t model_q [NCH][$];

   req_dispatch_queue #(
      .ADDRW(ADDRW), .OPCODEW(OPCODEW), .QDEPTH(QDEPTH), .NCH(NCH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .key_addr(key_addr), .text_addr(text_addr), .dest_addr(dest_addr),
      .out_instr(out_instr), .out_valid(out_valid), .out_ready(out_ready),
      .flush(flush), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic entry_t mk(input logic [OPCODEW-1:0] op, input logic [ADDRW-1:0] k,
                                 input logic [ADDRW-1:0] t, input logic [ADDRW-1:0] d);
      return {op, k, t, d};
   endfunction

   // Monitor: checks what the DUT shows before each edge, then applies that edge to the model.
   logic exp_ready;
   int   sel;
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_out_valid", 256'(out_valid), 256'(0));
         check("rst_count", 256'(count), 256'(0));
         check("rst_out_instr", 256'(out_instr), 256'(0));
         for (int c = 0; c < NCH; c++) model_q[c].delete();
      end else begin
         sel = int'(opcode) % NCH;
         exp_ready = (model_q[sel].size() < QDEPTH) && !flush[sel];
         check("in_ready", 256'(in_ready), 256'(exp_ready));
         for (int c = 0; c < NCH; c++) begin
            check($sformatf("count%0d", c), 256'(count[c*CNTW +: CNTW]), 256'(model_q[c].size()));
            check($sformatf("out_valid%0d", c), 256'(out_valid[c]), 256'(model_q[c].size() != 0));
            if (model_q[c].size() != 0)
               check($sformatf("head%0d", c), 256'(out_instr[c*INSTRW +: INSTRW]), 256'(model_q[c][0]));
            if (flush[c])
               model_q[c].delete();
            else if (out_ready[c] && model_q[c].size() != 0)
               void'(model_q[c].pop_front());
         end
         if (in_valid && exp_ready)
            model_q[sel].push_back(mk(opcode, key_addr, text_addr, dest_addr));
      end
   end

   // All stimulus tasks start and end one time unit after a rising edge.
   task automatic push(input logic [OPCODEW-1:0] op, input logic [ADDRW-1:0] k,
                       input logic [ADDRW-1:0] t, input logic [ADDRW-1:0] d);
      opcode = op; key_addr = k; text_addr = t; dest_addr = d; in_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (!in_ready) check("push_accept_timeout", 256'(in_ready), 256'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic push_rand(input logic [OPCODEW-1:0] op);
      push(op, ADDRW'($urandom), ADDRW'($urandom), ADDRW'($urandom));
   endtask

   task automatic drain();
      out_ready = '1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (out_valid == '0) break;
      end
      check("drain_empty", 256'(out_valid), 256'(0));
      @(posedge clk); #1;
      out_ready = '0;
   endtask

   entry_t saved;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; opcode = '0; key_addr = '0; text_addr = '0;
      dest_addr = '0; out_ready = '0; flush = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("init_in_ready", 256'(in_ready), 256'(1));
      check("init_count", 256'(count), 256'(0));
      @(posedge clk); #1;

      // Routing by opcode
      push(2'b00, 24'h000011, 24'h000022, 24'h000033);
      push(2'b01, 24'h0000AA, 24'h0000BB, 24'h0000CC);
      @(negedge clk);
      check("route_ch0_head", 256'(out_instr[0 +: INSTRW]), 256'({2'b00, 24'h000011, 24'h000022, 24'h000033}));
      check("route_ch1_key", 256'(out_instr[INSTRW + 2*ADDRW +: ADDRW]), 256'(24'h0000AA));
      check("route_count0", 256'(count[0 +: CNTW]), 256'(1));
      check("route_count1", 256'(count[CNTW +: CNTW]), 256'(1));
      @(posedge clk); #1;
      drain();

      // Full channel 0 blocks only ch0 requests; held request goes in after a pop
      repeat (4) push_rand(2'b00);
      opcode = 2'b00;
      @(negedge clk);
      check("full_count0", 256'(count[0 +: CNTW]), 256'(4));
      check("full_ready_ch0", 256'(in_ready), 256'(0));
      opcode = 2'b01; #1;
      check("full_ready_ch1", 256'(in_ready), 256'(1));
      @(posedge clk); #1;
      opcode = 2'b00; key_addr = 24'h5A5A5A; text_addr = 24'hC3C3C3; dest_addr = 24'h0F0F0F;
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("full_held", 256'(in_ready), 256'(0));
         @(posedge clk); #1;
      end
      out_ready = 2'b01;
      @(posedge clk); #1;
      out_ready = 2'b00;
      @(negedge clk);
      check("full_after_pop_count0", 256'(count[0 +: CNTW]), 256'(3));
      check("full_after_pop_ready", 256'(in_ready), 256'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("full_refill_count0", 256'(count[0 +: CNTW]), 256'(4));
      @(posedge clk); #1;
      drain();

      // Concurrent push and pop on ch0 across pointer wrap; opcode[1] is carried but not decoded
      push_rand(2'b00);
      push_rand(2'b10);
      out_ready = 2'b01;
      for (int i = 0; i < 10; i++) begin
         opcode = {1'($urandom), 1'b0};
         key_addr = ADDRW'($urandom); text_addr = ADDRW'($urandom); dest_addr = ADDRW'($urandom);
         in_valid = 1'b1;
         @(negedge clk);
         check("conc_count0", 256'(count[0 +: CNTW]), 256'(2));
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = '0;
      drain();

      // Flush of ch1 blocks the ch1 push, ignores the pop, and leaves ch0 alone
      repeat (3) push_rand(2'b01);
      saved = mk(2'b00, 24'h123456, 24'h789ABC, 24'hDEF012);
      push(2'b00, 24'h123456, 24'h789ABC, 24'hDEF012);
      flush = 2'b10; opcode = 2'b01; in_valid = 1'b1; out_ready = 2'b10;
      @(negedge clk);
      check("flush_in_ready", 256'(in_ready), 256'(0));
      @(posedge clk); #1;
      flush = '0; in_valid = 1'b0; out_ready = '0;
      @(negedge clk);
      check("flush_count1", 256'(count[CNTW +: CNTW]), 256'(0));
      check("flush_valid1", 256'(out_valid[1]), 256'(0));
      check("flush_count0", 256'(count[0 +: CNTW]), 256'(1));
      check("flush_ch0_head", 256'(out_instr[0 +: INSTRW]), 256'(saved));
      @(posedge clk); #1;
      drain();

      // Asynchronous reset with entries in flight
      push_rand(2'b00);
      push_rand(2'b01);
      push_rand(2'b00);
      #3 rst_n = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", 256'(out_valid), 256'(0));
      check("midrst_count", 256'(count), 256'(0));
      check("midrst_out_instr", 256'(out_instr), 256'(0));
      @(posedge clk); #1;
      rst_n = 1'b1; opcode = 2'b00;
      @(negedge clk);
      check("midrst_in_ready", 256'(in_ready), 256'(1));
      @(posedge clk); #1;

      // Random traffic against the model
      for (int i = 0; i < 10000; i++) begin
         in_valid  = 1'($urandom);
         opcode    = OPCODEW'($urandom);
         key_addr  = ADDRW'($urandom);
         text_addr = ADDRW'($urandom);
         dest_addr = ADDRW'($urandom);
         out_ready = NCH'($urandom);
         flush     = ($urandom_range(0, 31) == 0) ? NCH'($urandom) : '0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; flush = '0;
      drain();
      @(negedge clk);
      check("final_count", 256'(count), 256'(0));
      check("final_model_empty0", 256'(model_q[0].size()), 256'(0));
      check("final_model_empty1", 256'(model_q[1].size()), 256'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
